// File: rtl/router_output_arbiter_pkg.sv
// router_output_arbiter_pkg: shared router sizing, arbiter state encoding and flit type
package router_output_arbiter_pkg;
    localparam int NPORT = 5;
    localparam int FLIT_WIDTH = 16;
    typedef enum logic [1:0] {ARB_IDLE, ARB_HEADER, ARB_SIZE, ARB_PAYLOAD} arb_state_t;
    typedef logic [FLIT_WIDTH-1:0] flit_t;
endpackage

// File: rtl/router_output_arbiter_if.sv
// router_output_arbiter_if: input-buffer side and TX side of one router output port
interface router_output_arbiter_if #(
    parameter int NPORT = router_output_arbiter_pkg::NPORT,
    parameter int FLIT_WIDTH = router_output_arbiter_pkg::FLIT_WIDTH
);
    logic [NPORT-1:0]            req;
    logic [NPORT-1:0]            flit_valid;
    logic [NPORT*FLIT_WIDTH-1:0] data_in;
    logic [NPORT-1:0]            flit_ack;
    logic [NPORT-1:0]            grant;
    logic                        tx;
    logic [FLIT_WIDTH-1:0]       data_out;
    logic                        credit_i;
    logic                        busy;
    modport master (
        output req, flit_valid, data_in, credit_i,
        input  flit_ack, grant, tx, data_out, busy
    );
    modport slave (
        input  req, flit_valid, data_in, credit_i,
        output flit_ack, grant, tx, data_out, busy
    );
endinterface

// File: rtl/router_output_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap
module rr_arbiter #(
    parameter int N = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    int idx;
    // Scan from farthest to nearest so the nearest request wins the last write
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) gnt = N'(1) << idx;
        end
    end
endmodule

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: per-output-port packet allocator with credit-gated flit forwarding
module router_output_arbiter
    import router_output_arbiter_pkg::*;
#(
    parameter int NPORT = router_output_arbiter_pkg::NPORT,
    parameter int FLIT_WIDTH = router_output_arbiter_pkg::FLIT_WIDTH,
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input logic clock,
    input logic reset,
    router_output_arbiter_if.slave bus
);
    arb_state_t                          state;
    logic [NPORT-1:0]                    grant_q;
    logic [PW-1:0]                       rr_ptr;
    logic [FLIT_WIDTH-1:0]               flit_cnt;
    logic [PW-1:0]                       g;
    logic [NPORT-1:0]                    arb_gnt;
    logic [NPORT-1:0][FLIT_WIDTH-1:0]    lanes;
    logic [FLIT_WIDTH-1:0]               cur;
    logic                                xfer;
    logic                                last;
    rr_arbiter #(.N(NPORT)) u_rr (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );
    always_comb begin
        g = '0;
        for (int k = 0; k < NPORT; k++) if (grant_q[k]) g = PW'(k);
    end
    assign lanes = bus.data_in;
    assign cur = lanes[g];
    assign xfer = (state != ARB_IDLE) & bus.flit_valid[g] & bus.credit_i;
    assign last = xfer & ((state == ARB_SIZE && cur == '0) ||
                          (state == ARB_PAYLOAD && flit_cnt == FLIT_WIDTH'(1)));
    assign bus.tx = xfer;
    assign bus.flit_ack = xfer ? grant_q : '0;
    assign bus.data_out = xfer ? cur : '0;
    assign bus.grant = grant_q;
    assign bus.busy = state != ARB_IDLE;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr   <= '0;
            flit_cnt <= '0;
        end else if (last) begin
            // Release: next search starts just past the input that owned the port
            state   <= ARB_IDLE;
            grant_q <= '0;
            rr_ptr  <= (g == PW'(NPORT - 1)) ? '0 : g + 1'b1;
            if (state == ARB_PAYLOAD) flit_cnt <= flit_cnt - 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|bus.req) begin
                        grant_q <= arb_gnt;
                        state   <= ARB_HEADER;
                    end
                end
                ARB_HEADER: if (xfer) state <= ARB_SIZE;
                ARB_SIZE: begin
                    if (xfer) begin
                        flit_cnt <= cur;
                        state    <= ARB_PAYLOAD;
                    end
                end
                ARB_PAYLOAD: if (xfer) flit_cnt <= flit_cnt - 1'b1;
                default: state <= ARB_IDLE;
            endcase
        end
    end
    a_grant_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant_q));
    a_tx_busy: assert property (@(posedge clock) disable iff (!reset) bus.tx |-> bus.busy);
    a_ack_grant: assert property (@(posedge clock) disable iff (!reset)
        bus.flit_ack == (grant_q & {NPORT{bus.tx}}));
endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: directed packet scenarios with hand-computed expectations
module tb_router_output_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    router_output_arbiter_if bus ();
    router_output_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic quiet(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_tx"}, 32'(bus.tx), 32'h0);
        check({tag, "_ack"}, 32'(bus.flit_ack), 32'h0);
        check({tag, "_dout"}, 32'(bus.data_out), 32'h0);
    endtask
    task automatic xmit(input int ln, input logic [15:0] d);
        logic [4:0] oh;
        oh = 5'b1 << ln;
        bus.data_in[ln*16 +: 16] = d;
        bus.flit_valid[ln] = 1'b1;
        #1;
        check("xfer_tx", 32'(bus.tx), 32'h1);
        check("xfer_dout", 32'(bus.data_out), 32'(d));
        check("xfer_ack", 32'(bus.flit_ack), 32'(oh));
        tick;
    endtask
    initial begin
        bus.req = '0;
        bus.flit_valid = '0;
        bus.data_in = '0;
        bus.credit_i = 1'b1;
        #2;
        quiet("in_reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        quiet("post_reset");
        // single packet on input 1; nothing moves in the arbitration cycle
        bus.req = 5'b00010;
        bus.flit_valid[1] = 1'b1;
        bus.data_in[16 +: 16] = 16'h0012;
        #1;
        check("sp_idle_tx", 32'(bus.tx), 32'h0);
        check("sp_idle_grant", 32'(bus.grant), 32'h0);
        tick;
        check("sp_grant", 32'(bus.grant), 32'h02);
        bus.req = '0;
        xmit(1, 16'h0012);
        xmit(1, 16'h0003);
        xmit(1, 16'h00A0);
        xmit(1, 16'h00B0);
        check("sp_busy", 32'(bus.busy), 32'h1);
        xmit(1, 16'h00C0);
        quiet("sp_done");
        bus.flit_valid = '0;
        // zero payload; rr_ptr=2 so input 2 beats input 0
        bus.req = 5'b00101;
        bus.flit_valid = 5'b00101;
        tick;
        check("zp_grant", 32'(bus.grant), 32'h04);
        bus.req = '0;
        xmit(2, 16'h0055);
        xmit(2, 16'h0000);
        quiet("zp_done");
        bus.flit_valid = '0;
        // no preemption: input 3 keeps the port while input 0 asks
        bus.req = 5'b01000;
        tick;
        check("np_grant", 32'(bus.grant), 32'h08);
        xmit(3, 16'h0030);
        bus.req = 5'b01001;
        bus.flit_valid[0] = 1'b1;
        xmit(3, 16'h0002);
        check("np_hold1", 32'(bus.grant), 32'h08);
        xmit(3, 16'h3001);
        check("np_hold2", 32'(bus.grant), 32'h08);
        xmit(3, 16'h3002);
        check("np_release", 32'(bus.grant), 32'h0);
        check("np_bubble_tx", 32'(bus.tx), 32'h0);
        tick;
        check("np_next", 32'(bus.grant), 32'h01);
        bus.req = '0;
        xmit(0, 16'h0040);
        xmit(0, 16'h0000);
        quiet("np_done");
        bus.flit_valid = '0;
        // backpressure during payload: credit 1,0,0,1
        bus.req = 5'b00010;
        tick;
        check("bp_grant", 32'(bus.grant), 32'h02);
        bus.req = '0;
        xmit(1, 16'h0011);
        xmit(1, 16'h0003);
        xmit(1, 16'h0B01);
        bus.data_in[16 +: 16] = 16'h0B02;
        bus.credit_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("bp_tx", 32'(bus.tx), 32'h0);
            check("bp_ack", 32'(bus.flit_ack), 32'h0);
            check("bp_dout", 32'(bus.data_out), 32'h0);
            check("bp_busy", 32'(bus.busy), 32'h1);
            tick;
        end
        bus.credit_i = 1'b1;
        xmit(1, 16'h0B02);
        check("bp_busy_mid", 32'(bus.busy), 32'h1);
        xmit(1, 16'h0B03);
        quiet("bp_done");
        bus.flit_valid = '0;
        // reset mid-packet abandons it; a fresh header follows the re-grant
        bus.req = 5'b00100;
        tick;
        check("rs_grant", 32'(bus.grant), 32'h04);
        xmit(2, 16'h0077);
        xmit(2, 16'h0004);
        xmit(2, 16'h0101);
        xmit(2, 16'h0102);
        bus.data_in[32 +: 16] = 16'h0103;
        reset = 1'b0;
        #1;
        quiet("rs_async");
        tick;
        reset = 1'b1;
        #1;
        check("rs_idle_tx", 32'(bus.tx), 32'h0);
        tick;
        check("rs_regrant", 32'(bus.grant), 32'h04);
        xmit(2, 16'h0078);
        check("rs_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        bus.req = '0;
        bus.flit_valid = '0;
        #1;
        quiet("rs_clear");
        // round robin from rr_ptr=0 with everyone requesting
        bus.req = 5'b11111;
        bus.flit_valid = 5'b11111;
        for (int p = 0; p < 6; p++) begin
            int e;
            e = p % 5;
            check("rr_bubble", 32'(bus.busy), 32'h0);
            tick;
            check("rr_grant", 32'(bus.grant), 32'(5'b1 << e));
            xmit(e, 16'h1000 + 16'(p));
            xmit(e, 16'h0001);
            xmit(e, 16'h2000 + 16'(p));
        end
        bus.req = '0;
        bus.flit_valid = '0;
        #1;
        quiet("rr_done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
